// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//   Multiply/divide unit controller for the E stage of a pipelined MIPS core.
//   Results of mult/multu/div/divu are computed when the instruction issues,
//   held in pending registers and committed into HI/LO after a fixed busy
//   window, so the rest of the pipeline sees a multi-cycle MDU.  mthi/mtlo
//   write HI/LO immediately.
//
//   Optional feature: define MDU_CTRL_ABORT_EN to add the i_abort input,
//   which cancels an in-flight mult/div without touching HI/LO.
//
// Parameters
//   MUL_CYCLES  busy duration of mult/multu (>= 1)
//   DIV_CYCLES  busy duration of div/divu   (>= 1)
//
// Ports
//   i_clk       clock, rising edge
//   i_reset     synchronous reset, active low
//   i_start     issue strobe for mult/div/mthi/mtlo, one cycle per instruction
//   i_op        000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   i_src_a     forwarded rs value
//   i_src_b     forwarded rt value
//   i_d_is_md   D stage holds an MDU-related instruction
//   i_abort     (MDU_CTRL_ABORT_EN only) cancel the running operation
//   o_busy      multi-cycle operation in progress
//   o_stall_md  stall request toward the hazard unit
//   o_hi/o_lo   committed HI/LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic        i_d_is_md,
`ifdef MDU_CTRL_ABORT_EN
    input  logic        i_abort,
`endif
    output logic        o_busy,
    output logic        o_stall_md,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 4) ? $clog2(MAX_CYC) : 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;

    logic               w_load_pend;
    logic               w_commit;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_is_div;
    logic               w_is_md_op;
    logic [63:0]        w_res;
    logic               w_res_wr;

    // Two's complement product of sign- or zero-extended operands; the low
    // 64 bits of the unsigned product equal the signed product.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}.  Works on magnitudes so that
    // 0x80000000 / -1 yields 0x80000000 with no overflow trap; quotient
    // truncates toward zero and remainder follows the dividend sign.
    function automatic logic [63:0] div64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic        na;
        logic        nb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = ~q + 32'd1;
        if (na)      r = ~r + 32'd1;
        return {r, q};
    endfunction

    assign w_is_div   = i_op[1];
    assign w_is_md_op = (i_op[2] == 1'b0);
    assign w_res      = w_is_div ? div64(i_src_a, i_src_b, ~i_op[0])
                                 : mul64(i_src_a, i_src_b, ~i_op[0]);
    // A zero divisor leaves HI/LO untouched when the window closes.
    assign w_res_wr   = !(w_is_div && (i_src_b == 32'd0));

    assign o_busy     = (r_state != S_IDLE);
    assign o_stall_md = i_d_is_md & (o_busy | (i_start & w_is_md_op));
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_pend = 1'b0;
        w_commit    = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    case (i_op)
                        3'b000, 3'b001: begin
                            w_state_nxt = S_MUL;
                            w_cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
                            w_load_pend = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            w_state_nxt = S_DIV;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                            w_load_pend = 1'b1;
                        end
                        3'b100:  w_wr_hi = 1'b1;
                        3'b101:  w_wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
`ifdef MDU_CTRL_ABORT_EN
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b0;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            if (w_load_pend) begin
                r_pend_hi <= w_res[63:32];
                r_pend_lo <= w_res[31:0];
                r_pend_wr <= w_res_wr;
            end
            if (w_commit && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_wr_hi) r_hi <= i_src_a;
            if (w_wr_lo) r_lo <= i_src_a;
        end
    end

endmodule
